// File: rtl/cbus_burst_ram_pkg.sv
// rtl/cbus_burst_ram_pkg.sv - cbus request/response types and burst-length helpers
package cbus_burst_ram_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  strobe_t;

    typedef enum logic [1:0] {
        MSIZE_BYTE = 2'd0,
        MSIZE_HALF = 2'd1,
        MSIZE_WORD = 2'd2,
        MSIZE_RSVD = 2'd3
    } msize_t;

    // len encodes beats-1, so legal values are also the wrap masks
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } cbus_len_t;

    localparam int IDX_W = 4;

    typedef struct packed {
        logic      valid;
        logic      is_write;
        msize_t    size;
        logic [31:0] addr;
        strobe_t   strobe;
        word_t     data;
        cbus_len_t len;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    function automatic logic len_legal(cbus_len_t len);
        case (len)
            MLEN1, MLEN2, MLEN4, MLEN8, MLEN16: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // Low word-address bits that rotate within the aligned burst block
    function automatic logic [IDX_W-1:0] wrap_mask(cbus_len_t len);
        return len;
    endfunction

endpackage

// File: rtl/cbus_burst_ram_lfsr8.sv
// rtl/cbus_burst_ram_lfsr8.sv - 8-bit Fibonacci LFSR stall source, built only with CBUS_RAM_STALL_EN
`ifdef CBUS_RAM_STALL_EN
module lfsr8 (
    input  logic       clk,
    input  logic       resetn,
    output logic [7:0] out
);

    // Taps 8,6,5,4; free-runs from seed 8'hA5 every cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out <= 8'hA5;
        end else begin
            out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
        end
    end

endmodule
`endif

// File: rtl/cbus_burst_ram.sv
// rtl/cbus_burst_ram.sv - cbus slave serving wrapping single/burst reads and writes from a word array (optional CBUS_RAM_STALL_EN)
module cbus_burst_ram
    import cbus_burst_ram_pkg::*;
#(
    parameter int WORDS_LOG2 = 12
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int DEPTH = 1 << WORDS_LOG2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [WORDS_LOG2-1:0]   base;
    cbus_len_t               len_q;
    logic                    is_write_q;

    logic                    stall;
    logic                    beat;
    logic                    last_beat;
    logic [IDX_W-1:0]        mask;
    logic [IDX_W-1:0]        rot;
    logic [WORDS_LOG2-1:0]   beat_addr;
    word_t                   mem [0:DEPTH-1];

    logic unused_req;
    assign unused_req = ^{creq.size, creq.addr[31:WORDS_LOG2+2], creq.addr[1:0]};

`ifdef CBUS_RAM_STALL_EN
    logic [7:0] lfsr_out;
    logic       unused_lfsr;

    lfsr8 u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .out    (lfsr_out)
    );

    assign stall       = lfsr_out[0];
    assign unused_lfsr = ^lfsr_out[7:1];
`else
    assign stall = 1'b0;
`endif

    assign beat      = (state == RUN) && !stall;
    assign last_beat = beat && (idx == len_q);

    // Wrap inside the aligned block: high bits fixed, masked low bits advance by idx
    assign mask      = wrap_mask(len_q);
    assign rot       = base[IDX_W-1:0] + idx;
    assign beat_addr = {base[WORDS_LOG2-1:IDX_W], (base[IDX_W-1:0] & ~mask) | (rot & mask)};

    // Transaction FSM: latch the request in IDLE, step one beat per unstalled RUN cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= '0;
            base       <= '0;
            len_q      <= MLEN1;
            is_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (creq.valid) begin
                        base       <= creq.addr[WORDS_LOG2+1:2];
                        len_q      <= creq.len;
                        is_write_q <= creq.is_write;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (idx == len_q) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte-lane write of the current beat; contents survive reset
    always_ff @(posedge clk) begin
        if (beat && is_write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (creq.strobe[b]) begin
                    mem[beat_addr][8*b +: 8] <= creq.data[8*b +: 8];
                end
            end
        end
    end

    // Response: read data is presented only while a read burst is running
    always_comb begin
        cresp       = '0;
        cresp.ready = beat;
        cresp.last  = last_beat;
        if (state == RUN && !is_write_q) begin
            cresp.data = mem[beat_addr];
        end
    end

    a_len_legal: assert property (@(posedge clk) disable iff (!resetn)
        (state == IDLE && creq.valid) |-> len_legal(creq.len));

    a_valid_held: assert property (@(posedge clk) disable iff (!resetn)
        (state == RUN) |-> creq.valid);

endmodule

// File: tb/tb_cbus_burst_ram.sv
// tb/tb_cbus_burst_ram.sv - randomized self-checking bench for cbus_burst_ram against an array model
module tb_cbus_burst_ram;
    import cbus_burst_ram_pkg::*;

    localparam int DEPTH = 4096;

    logic       clk;
    logic       resetn;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int n_checks = 0;
    int n_fail   = 0;

    word_t model [DEPTH];
    word_t wbuf  [16];
    word_t rbuf  [16];
    bit    lastbuf [16];
    int    first_lat;
    int    run_cycles;
    int    stall_cycles;
    int    bad_last;
    bit    timeout;

    cbus_burst_ram #(.WORDS_LOG2(12)) dut (
        .clk    (clk),
        .resetn (resetn),
        .creq   (creq),
        .cresp  (cresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int beat_word(logic [31:0] addr, int len, int i);
        int base;
        int beats;
        int off;
        base  = int'((addr >> 2) % DEPTH);
        beats = len + 1;
        off   = base % beats;
        return base - off + (off + i) % beats;
    endfunction

    task automatic run_txn(input bit wr, input logic [31:0] addr, input int len,
                           input logic [3:0] strb, input int stop_after);
        int beat;
        int cyc;
        int a;
        beat = 0;
        cyc  = 0;
        first_lat    = -1;
        timeout      = 1'b0;
        stall_cycles = 0;
        bad_last     = 0;
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.size     = msize_t'($urandom_range(3, 0));
        creq.addr     = addr;
        creq.strobe   = strb;
        creq.data     = wbuf[0];
        creq.len      = cbus_len_t'(len[3:0]);
        while (beat < stop_after) begin
            @(negedge clk);
            cyc++;
            if (cyc > 200) begin
                timeout = 1'b1;
                break;
            end
            if (cresp.ready) begin
                if (first_lat < 0) first_lat = cyc - 1;
                rbuf[beat]    = cresp.data;
                lastbuf[beat] = cresp.last;
                if (wr) begin
                    a = beat_word(addr, len, beat);
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) model[a][8*b +: 8] = wbuf[beat][8*b +: 8];
                end
                beat++;
                @(posedge clk);
                #1;
                if (beat < len + 1) creq.data = wbuf[beat];
            end else begin
                if (cresp.last) bad_last++;
                if (cyc > 1) stall_cycles++;
                @(posedge clk);
                #1;
            end
        end
        run_cycles = cyc - 1;
    endtask

    task automatic idle_bus();
        creq.valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        creq   = '0;
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.addr     = 32'h14;
        creq.strobe   = 4'hF;
        creq.data     = 32'hDEADBEEF;
        creq.len      = MLEN1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (cresp.ready !== 1'b0 || cresp.last !== 1'b0 || cresp.data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: ready=%b last=%b data=%h expected 0 0 0",
                         c, cresp.ready, cresp.last, cresp.data);
            end
        end
        @(posedge clk);
        #1;
        creq.valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_preload();
        int touts;
        touts = 0;
        for (int k = 0; k < DEPTH / 16; k++) begin
            for (int i = 0; i < 16; i++) wbuf[i] = k * 16 + i;
            run_txn(1'b1, k * 64, 15, 4'hF, 16);
            if (timeout) touts++;
        end
        idle_bus();
        n_checks++;
        if (touts !== 0) begin
            n_fail++;
            $display("FAIL preload_timeouts: got %0d expected 0", touts);
        end
    endtask

    task automatic test_reset_no_write();
        word_t exp;
        exp = model[5];
        test_reset();
        run_txn(1'b0, 32'h14, 0, 4'h0, 1);
        idle_bus();
        n_checks++;
        if (timeout || rbuf[0] !== exp || exp !== 32'h5) begin
            n_fail++;
            $display("FAIL reset_no_write: got %h expected 00000005 (timeout=%0d)", rbuf[0], timeout);
        end
    endtask

    task automatic test_read_wrap();
        run_txn(1'b0, 32'h28, 15, 4'h0, 16);
        idle_bus();
        n_checks++;
        if (timeout) begin
            n_fail++;
            $display("FAIL read_wrap_timeout: burst did not complete");
        end
`ifndef CBUS_RAM_STALL_EN
        n_checks++;
        if (first_lat !== 1) begin
            n_fail++;
            $display("FAIL read_wrap_latency: got %0d expected 1", first_lat);
        end
        n_checks++;
        if (stall_cycles !== 0) begin
            n_fail++;
            $display("FAIL read_wrap_no_stall: got %0d ready-low RUN cycles expected 0", stall_cycles);
        end
`else
        n_checks++;
        if (run_cycles <= 16) begin
            n_fail++;
            $display("FAIL read_wrap_stall_cycles: got %0d RUN cycles expected more than 16", run_cycles);
        end
`endif
        n_checks++;
        if (bad_last !== 0) begin
            n_fail++;
            $display("FAIL read_wrap_last_without_ready: got %0d expected 0", bad_last);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (rbuf[i] !== word_t'((10 + i) % 16) || lastbuf[i] !== (i == 15)) begin
                n_fail++;
                $display("FAIL read_wrap beat %0d: data=%h last=%b expected %h %b",
                         i, rbuf[i], lastbuf[i], (10 + i) % 16, (i == 15));
            end
        end
    endtask

    task automatic test_write_burst();
        for (int i = 0; i < 16; i++) wbuf[i] = 32'hD0 + i;
        run_txn(1'b1, 32'h40, 15, 4'hF, 16);
        run_txn(1'b0, 32'h40, 15, 4'h0, 16);
        idle_bus();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (timeout || rbuf[i] !== 32'hD0 + i) begin
                n_fail++;
                $display("FAIL write_burst beat %0d: got %h expected %h", i, rbuf[i], 32'hD0 + i);
            end
        end
    endtask

    task automatic test_strobe();
        wbuf[0] = 32'h11223344;
        run_txn(1'b1, 32'h0C, 0, 4'hF, 1);
        wbuf[0] = 32'hAABBCCDD;
        run_txn(1'b1, 32'h0C, 0, 4'b0101, 1);
        idle_bus();
        run_txn(1'b0, 32'h0C, 0, 4'h0, 1);
        idle_bus();
        n_checks++;
        if (timeout || rbuf[0] !== 32'h11BB33DD || lastbuf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL strobe_merge: got %h last=%b expected 11bb33dd 1", rbuf[0], lastbuf[0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
        run_txn(1'b1, 32'h80, 15, 4'hF, 5);
        resetn = 1'b0;
        #1;
        n_checks++;
        if (cresp.ready !== 1'b0 || cresp.last !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: ready=%b last=%b expected 0 0", cresp.ready, cresp.last);
        end
        creq.valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (cresp.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: ready=%b expected 0", cresp.ready);
        end
        run_txn(1'b0, 32'h80, 15, 4'h0, 16);
        idle_bus();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (timeout || rbuf[i] !== (i < 5 ? wbuf[i] : word_t'(32'h20 + i))) begin
                n_fail++;
                $display("FAIL mid_reset_word %0d: got %h expected %h", i, rbuf[i],
                         (i < 5 ? wbuf[i] : word_t'(32'h20 + i)));
            end
        end
    endtask

    task automatic test_random();
        int lens [5] = '{0, 1, 3, 7, 15};
        int len;
        logic [31:0] addr;
        bit wr;
        for (int t = 0; t < 80; t++) begin
            len  = lens[$urandom_range(4, 0)];
            addr = $urandom;
            wr   = $urandom_range(1, 0);
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            run_txn(wr, addr, len, 4'($urandom), len + 1);
            if (wr && $urandom_range(1, 0)) begin
                run_txn(1'b0, addr, len, 4'h0, len + 1);
                wr = 1'b0;
            end
            if (!wr) begin
                for (int i = 0; i <= len; i++) begin
                    n_checks++;
                    if (timeout || rbuf[i] !== model[beat_word(addr, len, i)] ||
                        lastbuf[i] !== (i == len)) begin
                        n_fail++;
                        $display("FAIL random txn %0d addr %h len %0d beat %0d: data=%h last=%b expected %h %b",
                                 t, addr, len, i, rbuf[i], lastbuf[i],
                                 model[beat_word(addr, len, i)], (i == len));
                    end
                end
            end
            if ($urandom_range(1, 0)) idle_bus();
        end
        idle_bus();
    endtask

    initial begin
        creq   = '0;
        resetn = 1'b0;
        test_reset();
        test_preload();
        test_reset_no_write();
        test_read_wrap();
        test_write_burst();
        test_strobe();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
